// File: rtl/ofs_plat_axi_mem_rsp_credit_buffer.sv
// Response buffer that owns a credit pool. Requesters reserve credits per burst,
// responses land in a FIFO without backpressure, and each drained beat returns a credit.
module ofs_plat_axi_mem_rsp_credit_buffer #(
   parameter int DATA_WIDTH      = 512,
   parameter int DEPTH           = 64,
   parameter int MAX_BURST_BEATS = 16
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 rsv_valid,
   input  logic [$clog2(MAX_BURST_BEATS+1)-1:0] rsv_beats,
   output logic                                 rsv_ready,
   input  logic                                 rsp_in_valid,
   input  logic [DATA_WIDTH-1:0]                rsp_in_data,
   output logic                                 rsp_out_valid,
   output logic [DATA_WIDTH-1:0]                rsp_out_data,
   input  logic                                 rsp_out_ready,
   output logic [$clog2(DEPTH+1)-1:0]           credits,
   output logic                                 overflow,
   output logic                                 bad_rsv
);

   localparam int RW = $clog2(MAX_BURST_BEATS+1);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cr;
   logic [CW-1:0]         cr_next;
   logic [CW:0]           cr_sum;
   logic [RW-1:0]         charge;
   logic                  rsv_bad_beats;
   logic                  rsv_fire;
   logic                  deq;
   logic                  enq;
   logic                  full;
   logic                  drop;

   assign rsv_ready     = reset_n && (cr >= CW'(MAX_BURST_BEATS));
   assign rsv_fire      = rsv_valid && rsv_ready;
   assign rsp_out_valid = (cnt != '0);
   assign rsp_out_data  = mem[rd_ptr];
   assign deq           = rsp_out_valid && rsp_out_ready;
   assign full          = (cnt == CW'(DEPTH));
   assign enq           = reset_n && rsp_in_valid && (!full || deq);
   assign drop          = rsp_in_valid && full && !deq;
   assign credits       = cr;

   // Malformed reservations are charged the worst case so the pool stays conservative.
   always_comb begin
      rsv_bad_beats = (rsv_beats == '0) || (rsv_beats > RW'(MAX_BURST_BEATS));
      charge        = rsv_bad_beats ? RW'(MAX_BURST_BEATS) : rsv_beats;
   end

   // rsv_ready guarantees cr >= charge, so the sum cannot go negative; only clamp the top.
   always_comb begin
      cr_sum = {1'b0, cr} + (CW+1)'(deq);
      if (rsv_fire) begin
         cr_sum = cr_sum - (CW+1)'(charge);
      end
      cr_next = (cr_sum > (CW+1)'(DEPTH)) ? CW'(DEPTH) : cr_sum[CW-1:0];
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         mem[wr_ptr] <= rsp_in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         cr       <= CW'(DEPTH);
         overflow <= 1'b0;
         bad_rsv  <= 1'b0;
      end else begin
         cr <= cr_next;
         if (enq) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (enq && !deq) begin
            cnt <= cnt + 1'b1;
         end else if (deq && !enq) begin
            cnt <= cnt - 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         if (rsv_fire && rsv_bad_beats) begin
            bad_rsv <= 1'b1;
         end
      end
   end

endmodule
